// File: rtl/act_unit_vec.sv
// rtl/act_unit_vec.sv - CH-lane requantise (rounding shift) + activation + saturate, 2-stage valid/ready pipe
module act_unit_vec #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int CH        = 4,
  parameter int SHIFT_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                cfg_mode,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic [OUT_WIDTH-1:0]      cfg_clamp,
  input  logic [SHIFT_W-1:0]        cfg_leak_shift,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [CH*IN_WIDTH-1:0]    s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CH*OUT_WIDTH-1:0]   m_data,
  output logic                      m_last,
  input  logic                      sat_clr,
  output logic                      sat_flag
);

  localparam int XW = IN_WIDTH + 1;
  localparam logic [XW-1:0]        ONE  = XW'(1);
  localparam logic signed [XW-1:0] MAXV = XW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] MINV = ~MAXV;

  logic                      v1, v2, last1, sat2, adv2;
  logic [1:0]                mode1;
  logic [OUT_WIDTH-1:0]      clamp1;
  logic [SHIFT_W-1:0]        leak1;
  logic signed [XW-1:0]      r1 [CH];
  logic signed [XW-1:0]      rs [CH];
  logic [CH*OUT_WIDTH-1:0]   od;
  logic                      sat_any;

  assign adv2    = !v2 || m_ready;
  assign s_ready = !v1 || adv2;
  assign m_valid = v2;

  // Extra headroom bit keeps x + 2^(s-1) from wrapping at the positive rail.
  always_comb begin
    logic signed [XW-1:0] xe, sum;
    logic [XW-1:0]        rnd;
    rnd = (ONE << cfg_shift) >> 1;
    for (int k = 0; k < CH; k++) begin
      xe    = $signed({s_data[k*IN_WIDTH + IN_WIDTH - 1], s_data[k*IN_WIDTH +: IN_WIDTH]});
      sum   = xe + $signed(rnd);
      rs[k] = sum >>> cfg_shift;
    end
  end

  always_comb begin
    logic signed [XW-1:0] r, a, cl;
    od      = '0;
    sat_any = 1'b0;
    cl      = $signed({{(XW - OUT_WIDTH){1'b0}}, clamp1});
    for (int k = 0; k < CH; k++) begin
      r = r1[k];
      case (mode1)
        2'd1:    a = r[XW-1] ? '0 : r;
        2'd2:    a = r[XW-1] ? '0 : ((r > cl) ? cl : r);
        2'd3:    a = r[XW-1] ? (r >>> leak1) : r;
        default: a = r;
      endcase
      if (a > MAXV) begin
        a       = MAXV;
        sat_any = 1'b1;
      end else if (a < MINV) begin
        a       = MINV;
        sat_any = 1'b1;
      end
      od[k*OUT_WIDTH +: OUT_WIDTH] = a[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      last1  <= 1'b0;
      mode1  <= '0;
      clamp1 <= '0;
      leak1  <= '0;
      for (int k = 0; k < CH; k++) r1[k] <= '0;
    end else if (s_ready) begin
      v1 <= s_valid;
      if (s_valid) begin
        last1  <= s_last;
        mode1  <= cfg_mode;
        clamp1 <= cfg_clamp;
        leak1  <= cfg_leak_shift;
        for (int k = 0; k < CH; k++) r1[k] <= rs[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      m_data <= '0;
      m_last <= 1'b0;
      sat2   <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        m_data <= od;
        m_last <= last1;
        sat2   <= sat_any;
      end
    end
  end

  // Saturation is credited only when the beat actually leaves; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       sat_flag <= 1'b0;
    else if (v2 && m_ready && sat2)   sat_flag <= 1'b1;
    else if (sat_clr)                 sat_flag <= 1'b0;
  end

endmodule

// File: tb/tb_act_unit_vec.sv
// tb/tb_act_unit_vec.sv - scoreboard bench for act_unit_vec with directed vectors
module tb_act_unit_vec;
  localparam int IW = 16, OW = 8, CH = 4, SW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] cfg_mode = '0;
  logic [SW-1:0] cfg_shift = '0, cfg_leak_shift = '0;
  logic [OW-1:0] cfg_clamp = '0;
  logic s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [CH*IW-1:0] s_data = '0;
  logic m_valid, m_ready = 1'b1, m_last;
  logic [CH*OW-1:0] m_data;
  logic sat_clr = 1'b0, sat_flag;

  typedef logic [CH*OW:0] exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, out_count = 0;

  act_unit_vec #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CH(CH), .SHIFT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
    .cfg_clamp(cfg_clamp), .cfg_leak_shift(cfg_leak_shift),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sat_clr(sat_clr), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: a transfer is pending when m_valid && m_ready, sampled mid-cycle.
  initial forever begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && m_valid && m_ready) begin
      out_count++;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_beat: got %0h required none", {m_last, m_data});
      end else begin
        e = sb.pop_front();
        check("beat", {m_last, m_data}, e);
      end
    end
  end

  task automatic send(input int l0, l1, l2, l3, input logic last, input logic [1:0] mode,
                      input logic [SW-1:0] sh, input logic [OW-1:0] clamp, input logic [SW-1:0] leak,
                      input int e0, e1, e2, e3);
    logic ok;
    int n;
    ok = 1'b0; n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = {IW'(l3), IW'(l2), IW'(l1), IW'(l0)}; s_last = last;
    cfg_mode = mode; cfg_shift = sh; cfg_clamp = clamp; cfg_leak_shift = leak;
    while (!ok && n < 100) begin
      #3 ok = s_ready;
      @(posedge clk);
      if (!ok) @(negedge clk);
      n++;
    end
    if (ok) sb.push_back({last, OW'(e3), OW'(e2), OW'(e1), OW'(e0)});
    else begin
      tests++; fails++;
      $display("FAIL send_timeout: got s_ready 0 required 1");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    #4;
  endtask

  task automatic clear_sat();
    @(negedge clk) sat_clr = 1'b1;
    @(negedge clk) sat_clr = 1'b0;
    #2 check("sat_clr", sat_flag, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_s_ready", s_ready, 1);

    // ReLU with latency probe
    send(-10, 0, 5, 127, 1'b0, 2'd1, 4'd0, 8'd0, 4'd0, 0, 0, 5, 127);
    idle();
    #2 check("lat_edge1", m_valid, 0);
    @(negedge clk); #2 check("lat_edge2", m_valid, 1);
    drain();

    // Round-half-up, then saturation, then wide-intermediate rounding
    send(6, 5, -6, -7, 1'b0, 2'd0, 4'd2, 8'd0, 4'd0, 2, 1, -1, -2);
    idle(); drain();
    check("sat_after_round", sat_flag, 0);
    send(1000, -1000, 127, -128, 1'b1, 2'd0, 4'd0, 8'd0, 4'd0, 127, -128, 127, -128);
    idle(); drain();
    check("sat_set", sat_flag, 1);
    clear_sat();
    send(32767, -32768, 3, -3, 1'b0, 2'd0, 4'd1, 8'd0, 4'd0, 127, -128, 2, -1);
    idle(); drain();
    check("sat_wide", sat_flag, 1);
    clear_sat();

    // Clamp does not count as saturation; leaky floors
    send(10, 3, -2, 6, 1'b0, 2'd2, 4'd0, 8'd6, 4'd0, 6, 3, 0, 6);
    idle(); drain();
    check("sat_clamp", sat_flag, 0);
    send(-16, -1, 20, -1024, 1'b0, 2'd3, 4'd0, 8'd0, 4'd3, -2, -1, 20, -128);
    idle(); drain();
    check("sat_leak3", sat_flag, 0);
    send(-1000, -3, 300, 0, 1'b0, 2'd3, 4'd0, 8'd0, 4'd1, -128, -2, 127, 0);
    idle(); drain();
    check("sat_leak1", sat_flag, 1);

    // Set wins over a same-cycle clear: accept at N, transfer at N+2
    send(500, 0, 0, 0, 1'b0, 2'd0, 4'd0, 8'd0, 4'd0, 127, 0, 0, 0);
    idle();
    @(negedge clk) sat_clr = 1'b1;
    @(negedge clk) sat_clr = 1'b0;
    #2 check("sat_priority", sat_flag, 1);
    drain();
    clear_sat();

    // Config change mid-stream
    for (int i = 0; i < 5; i++) begin
      if (i < 3) send(-5, -5, -5, -5, 1'b0, 2'd1, 4'd0, 8'd0, 4'd0, 0, 0, 0, 0);
      else       send(-5, -5, -5, -5, 1'b0, 2'd0, 4'd0, 8'd0, 4'd0, -5, -5, -5, -5);
    end
    idle(); drain();

    // Backpressure: stall 3 cycles after the 2nd output
    begin
      int base;
      base = out_count;
      fork
        begin
          for (int i = 1; i <= 8; i++)
            send(i, 0, 0, 0, i == 8, 2'd0, 4'd0, 8'd0, 4'd0, i, 0, 0, 0);
          idle();
        end
        begin
          int n;
          logic [CH*OW-1:0] snap;
          n = 0;
          while (out_count < base + 2 && n < 100) begin
            @(negedge clk); #3; n++;
          end
          check("bp_two_out", out_count >= base + 2, 1);
          @(negedge clk); #1 m_ready = 1'b0;
          snap = m_data;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stall_data", m_data, snap);
            check("stall_valid", m_valid, 1);
            check("stall_s_ready", s_ready, 0);
          end
          m_ready = 1'b1;
        end
      join
      drain();
      check("bp_count", out_count - base, 8);
    end

    // Asynchronous reset with two beats held
    send(1000, 0, 0, 0, 1'b0, 2'd0, 4'd0, 8'd0, 4'd0, 127, 0, 0, 0);
    idle(); drain();
    check("pre_rst_sat", sat_flag, 1);
    m_ready = 1'b0;
    send(1, 0, 0, 0, 1'b0, 2'd0, 4'd0, 8'd0, 4'd0, 1, 0, 0, 0);
    send(2, 0, 0, 0, 1'b0, 2'd0, 4'd0, 8'd0, 4'd0, 2, 0, 0, 0);
    idle();
    #2 check("pre_rst_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_sat", sat_flag, 0);
    check("arst_m_data", m_data, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_ready = 1'b1;
    #1 check("rel_s_ready", s_ready, 1);
    repeat (6) @(negedge clk);
    send(-3, 4, 0, -128, 1'b1, 2'd1, 4'd0, 8'd0, 4'd0, 0, 4, 0, 0);
    idle(); drain();

    check("final_queue", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
